seq_divider: RTL



---
 rtl/seq_divider.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential restoring shift-subtract divider: 2*WIDTH-bit dividend by WIDTH-bit divisor.
// Retires one quotient bit per cycle; divide-by-zero and overflow short-circuit to DONE.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_zero,
    output logic                 overflow,
    output logic [1:0]           state_dbg
);
    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: start is sampled only in IDLE; done pulses for one cycle with results
    // already valid on quotient/remainder/flags; busy is high in RUN and DONE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH:0]     r_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   d_reg;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     s_val;
    logic [WIDTH:0]     t_val;
    logic               borrow;
    logic [WIDTH:0]     r_next;
    logic [WIDTH-1:0]   q_next;

    assign state_dbg = state;

    always_comb begin
        s_val  = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        t_val  = s_val - {1'b0, d_reg};
        // R[W] stays 0 because R < D after every step; keeping it in the test costs nothing.
        borrow = (s_val < {1'b0, d_reg}) && !r_reg[WIDTH];
        r_next = t_val;
        q_next = {q_reg[WIDTH-2:0], 1'b1};
        if (borrow) begin
            r_next = s_val;
            q_next = {q_reg[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        d_reg <= divisor;
                        r_reg <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
                        q_reg <= dividend[WIDTH-1:0];
                        busy  <= 1'b1;
                        if (divisor == '0) begin
                            div_zero  <= 1'b1;
                            overflow  <= 1'b0;
                            quotient  <= '1;
                            remainder <= '0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                            div_zero  <= 1'b0;
                            overflow  <= 1'b1;
                            quotient  <= '1;
                            remainder <= '0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            div_zero <= 1'b0;
                            overflow <= 1'b0;
                            cnt      <= CW'(WIDTH);
                            state    <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
